fofb_readout_sequencer: RTL and testbench
=========================================

FOFB_READOUT_SEQUENCER -- requirements
Module: fofb_readout_sequencer

Interface
REQ-001 Parameter FOFB_INDEX_WIDTH, default 9: width of the BPM readout address.
REQ-002 Parameter READ_LATENCY, default 1: sysClk cycles from address change to valid readout data.
REQ-003 Port sysClk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port sysResetN, input, 1: reset, synchronous and active-low.
REQ-005 Port FAstrobe, input, 1: one-cycle fast-acquisition tick that starts a cycle.
REQ-006 Port readoutValid, input, 1: level, all cells received for the current cycle.
REQ-007 Port readTimeout, input, 1: level, cell gathering timed out for the current cycle.
REQ-008 Port csrStrobe, input, 1: latches configuration from GPIO_OUT.
REQ-009 Port GPIO_OUT, input, 32: [FOFB_INDEX_WIDTH-1:0] is bpmCount (0 disables sweeps); [31] is forceSweep.
REQ-010 Port dspReady, input, 1: DSP accepts one address step this cycle.
REQ-011 Port readoutAddress, output, FOFB_INDEX_WIDTH: address driven to the link readout.
REQ-012 Port addressValid, output, 1: readoutAddress is a live sweep step.
REQ-013 Port dataValid, output, 1: readoutAddress delayed by READ_LATENCY, data at readout ports valid.
REQ-014 Port sweepActive, output, 1: high from sweep start until done.
REQ-015 Port sweepDone, output, 1: one-cycle pulse after the last dataValid.
REQ-016 Port staleSweep, output, 1: current/last sweep was started by timeout (held values).
REQ-017 Port status, output, 32: {overrunCount[7:0], lastSweepCycles[15:0], 6'b0, staleSweep, sweepActive}.

Function
REQ-018 States: IDLE, WAIT, SWEEP, DRAIN; the state is IDLE after reset.
REQ-019 IDLE: on FAstrobe with bpmCount!=0 -> WAIT; bpmCount==0 -> stay IDLE, no outputs.
REQ-020 WAIT: readoutValid -> SWEEP with staleSweep=0; readTimeout (no readoutValid) -> SWEEP with staleSweep=1.
REQ-021 WAIT: readoutValid and readTimeout together -> readoutValid wins.
REQ-022 WAIT: forceSweep=1 -> SWEEP next cycle regardless of inputs, with staleSweep=1.
REQ-023 SWEEP: readoutAddress starts at 0.
REQ-024 SWEEP: increments by 1 only in a cycle with addressValid && dspReady.
REQ-025 SWEEP: consecutive steps alternate the address LSB, required for downstream capture detection.
REQ-026 SWEEP: addressValid is high throughout SWEEP.
REQ-027 SWEEP: step at bpmCount-1 accepted -> DRAIN; the address holds bpmCount-1.
REQ-028 DRAIN: lasts READ_LATENCY cycles, then sweepDone pulses for 1 cycle -> IDLE.
REQ-029 dataValid is addressValid&&dspReady delayed exactly READ_LATENCY cycles.
REQ-030 FAstrobe in WAIT, SWEEP or DRAIN aborts the cycle: overrunCount saturating-increments at 255.
REQ-031 After an abort: the state goes to WAIT on the same edge, the address goes to 0, and sweepDone is not pulsed.
REQ-032 lastSweepCycles counts cycles from SWEEP entry to sweepDone, saturating at 0xFFFF, and is latched at sweepDone.
REQ-033 lastSweepCycles is not updated on abort.
REQ-034 csrStrobe during a sweep updates bpmCount only at the next IDLE/WAIT entry; the running sweep uses the latched count.
REQ-035 dspReady low stalls the address indefinitely; there is no timeout in SWEEP.

Reset
REQ-036 With sysResetN low at a clock edge, the reset values are: state=IDLE, readoutAddress=0, addressValid=0, dataValid=0, sweepActive=0, sweepDone=0, staleSweep=0.
REQ-037 Reset values of the stored counters and configuration: overrunCount=0, lastSweepCycles=0, bpmCount=0, forceSweep=0, latency pipe cleared.
REQ-038 Reset mid-sweep produces no sweepDone.
REQ-039 After reset, the first FAstrobe is honoured only after csrStrobe has set a nonzero bpmCount.

Configuration
REQ-040 With macro FOFB_SEQ_STATS_EN defined, overrunCount and lastSweepCycles are implemented per REQ-030/REQ-032.
REQ-041 Without FOFB_SEQ_STATS_EN, status[31:8] reads 0 and no counter logic is synthesized.
REQ-042 Without FOFB_SEQ_STATS_EN, abort behaviour is otherwise unchanged.

Structure
REQ-043 Shared package fofb_seq_pkg holds the state encoding (IDLE=0, WAIT=1, SWEEP=2, DRAIN=3).
REQ-044 fofb_seq_pkg also holds the GPIO_OUT field positions and the status field offsets.
REQ-045 One sub-module, fofb_seq_delay: a READ_LATENCY-deep shift register producing dataValid and the DRAIN terminal count.

Verification
REQ-046 Sweep: bpmCount=4, dspReady=1, FAstrobe then readoutValid -> addresses 0,1,2,3 on consecutive cycles, dataValid 1 cycle later, single sweepDone, lastSweepCycles=5 (latency 1).
REQ-047 Backpressure: dspReady toggling 1,0,1,0 with bpmCount=3 -> each address held through its 0 cycle, exactly 3 dataValid pulses.
REQ-048 Timeout: readTimeout without readoutValid -> full sweep with staleSweep=1; a following cycle with readoutValid -> staleSweep=0.
REQ-049 Overrun: FAstrobe at address 2 of 8 -> no sweepDone, overrunCount=1, state WAIT, address 0; 300 overruns -> overrunCount=255.
REQ-050 Reset/config: sysResetN low at address 5 -> all outputs 0 next cycle; bpmCount=0 -> FAstrobe ignored.
REQ-051 Reset/config: compile without FOFB_SEQ_STATS_EN -> status[31:8]=0 after overrun.

Source files
------------

// File: rtl/fofb_seq_pkg.sv
// fofb_seq_pkg: shared state encoding, GPIO_OUT field positions and status field offsets
package fofb_seq_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int GPIO_BPM_LSB   = 0;
    localparam int GPIO_FORCE_BIT = 31;

    localparam int ST_ACTIVE_BIT = 0;
    localparam int ST_STALE_BIT  = 1;
    localparam int ST_LAST_LSB   = 8;
    localparam int ST_OVR_LSB    = 24;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fofb_seq_delay.sv
// fofb_seq_delay: DEPTH-deep pipe for accepted steps (dataValid) and the final-step marker (drain end)
module fofb_seq_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic step_i,
    input  logic last_i,
    input  logic flush_i,
    output logic data_valid_o,
    output logic drain_done_o
);

    logic [DEPTH-1:0] step_q;
    logic [DEPTH-1:0] last_q;

    // Shift accepted steps and the last-step marker; an abort drops only the marker
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            step_q <= '0;
            last_q <= '0;
        end else begin
            step_q <= (step_q << 1) | DEPTH'(step_i);
            last_q <= flush_i ? '0 : ((last_q << 1) | DEPTH'(last_i));
        end
    end

    assign data_valid_o = step_q[DEPTH-1];
    assign drain_done_o = last_q[DEPTH-1];

endmodule

// File: rtl/fofb_readout_sequencer.sv
// fofb_readout_sequencer: per-FA-tick BPM readout address sweep; stats counters need FOFB_SEQ_STATS_EN
module fofb_readout_sequencer
    import fofb_seq_pkg::*;
#(
    parameter int FOFB_INDEX_WIDTH = 9,
    parameter int READ_LATENCY     = 1
) (
    input  logic                        sysClk,
    input  logic                        sysResetN,
    input  logic                        FAstrobe,
    input  logic                        readoutValid,
    input  logic                        readTimeout,
    input  logic                        csrStrobe,
    input  logic [31:0]                 GPIO_OUT,
    input  logic                        dspReady,
    output logic [FOFB_INDEX_WIDTH-1:0] readoutAddress,
    output logic                        addressValid,
    output logic                        dataValid,
    output logic                        sweepActive,
    output logic                        sweepDone,
    output logic                        staleSweep,
    output logic [31:0]                 status
);

    localparam int W = FOFB_INDEX_WIDTH;
    localparam logic [W-1:0] ONE = 1;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] bpm_q, bpm_d, pend_bpm_q, pend_bpm_d;
    logic         force_q, force_d, pend_force_q, pend_force_d;
    logic         stale_q, stale_d, done_q, done_d;
    logic         abort, enter_wait, last_step, drain_done;
    logic [7:0]   ovr;
    logic [15:0]  last_cyc;
    logic         gpio_unused;

    assign gpio_unused = ^GPIO_OUT[GPIO_FORCE_BIT-1:W];

    assign abort     = FAstrobe && state_q != S_IDLE;
    assign last_step = addressValid && dspReady && !abort && addr_q == bpm_q - ONE;

    // Sequencer FSM: a new FA tick outside IDLE aborts straight back to WAIT
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stale_d    = stale_q;
        done_d     = 1'b0;
        enter_wait = 1'b0;
        if (abort) begin
            state_d    = S_WAIT;
            addr_d     = '0;
            enter_wait = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (FAstrobe && pend_bpm_q != '0) begin
                        state_d    = S_WAIT;
                        enter_wait = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bpm_q == '0) begin
                        state_d = S_IDLE;
                    end else if (force_q || readoutValid || readTimeout) begin
                        state_d = S_SWEEP;
                        addr_d  = '0;
                        stale_d = force_q || !readoutValid;
                    end
                end
                S_SWEEP: begin
                    if (dspReady) begin
                        state_d = (addr_q == bpm_q - ONE) ? S_DRAIN : S_SWEEP;
                        addr_d  = (addr_q == bpm_q - ONE) ? addr_q : addr_q + ONE;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // CSR writes land in a shadow; the running sweep only sees them at the next WAIT entry
    always_comb begin
        pend_bpm_d   = csrStrobe ? GPIO_OUT[GPIO_BPM_LSB +: W] : pend_bpm_q;
        pend_force_d = csrStrobe ? GPIO_OUT[GPIO_FORCE_BIT] : pend_force_q;
        bpm_d        = enter_wait ? pend_bpm_q : bpm_q;
        force_d      = enter_wait ? pend_force_q : force_q;
    end

    // State, address and configuration registers
    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            bpm_q        <= '0;
            pend_bpm_q   <= '0;
            force_q      <= 1'b0;
            pend_force_q <= 1'b0;
            stale_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bpm_q        <= bpm_d;
            pend_bpm_q   <= pend_bpm_d;
            force_q      <= force_d;
            pend_force_q <= pend_force_d;
            stale_q      <= stale_d;
            done_q       <= done_d;
        end
    end

    fofb_seq_delay #(
        .DEPTH(READ_LATENCY)
    ) u_delay (
        .clk_i       (sysClk),
        .rst_n_i     (sysResetN),
        .step_i      (addressValid && dspReady),
        .last_i      (last_step),
        .flush_i     (abort),
        .data_valid_o(dataValid),
        .drain_done_o(drain_done)
    );

`ifdef FOFB_SEQ_STATS_EN
    logic [7:0]  ovr_q;
    logic [15:0] cyc_q, last_cyc_q;

    // Overrun count and sweep duration; the duration is latched only on a completed sweep
    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            ovr_q      <= '0;
            cyc_q      <= '0;
            last_cyc_q <= '0;
        end else begin
            ovr_q      <= abort ? sat_inc8(ovr_q) : ovr_q;
            cyc_q      <= sweepActive ? sat_inc16(cyc_q) : '0;
            last_cyc_q <= done_d ? sat_inc16(cyc_q) : last_cyc_q;
        end
    end

    assign ovr      = ovr_q;
    assign last_cyc = last_cyc_q;
`else
    assign ovr      = '0;
    assign last_cyc = '0;
`endif

    assign readoutAddress = addr_q;
    assign addressValid   = state_q == S_SWEEP;
    assign sweepActive    = state_q == S_SWEEP || state_q == S_DRAIN;
    assign sweepDone      = done_q;
    assign staleSweep     = stale_q;

    // Pack the status word from the field offsets
    always_comb begin
        status                     = '0;
        status[ST_ACTIVE_BIT]      = sweepActive;
        status[ST_STALE_BIT]       = staleSweep;
        status[ST_LAST_LSB +: 16]  = last_cyc;
        status[ST_OVR_LSB +: 8]    = ovr;
    end

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// tb_fofb_readout_sequencer: directed vector table plus hand sequences for abort, reset and config cases
module tb_fofb_readout_sequencer;

    localparam int W = 9;
`ifdef FOFB_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          sysClk = 1'b0;
    logic          sysResetN = 1'b0;
    logic          FAstrobe = 1'b0;
    logic          readoutValid = 1'b0;
    logic          readTimeout = 1'b0;
    logic          csrStrobe = 1'b0;
    logic [31:0]   GPIO_OUT = '0;
    logic          dspReady = 1'b1;
    logic [W-1:0]  readoutAddress;
    logic          addressValid, dataValid, sweepActive, sweepDone, staleSweep;
    logic [31:0]   status;

    int checks = 0;
    int errors = 0;

    always #5 sysClk = ~sysClk;

    fofb_readout_sequencer #(
        .FOFB_INDEX_WIDTH(W),
        .READ_LATENCY    (1)
    ) dut (
        .sysClk        (sysClk),
        .sysResetN     (sysResetN),
        .FAstrobe      (FAstrobe),
        .readoutValid  (readoutValid),
        .readTimeout   (readTimeout),
        .csrStrobe     (csrStrobe),
        .GPIO_OUT      (GPIO_OUT),
        .dspReady      (dspReady),
        .readoutAddress(readoutAddress),
        .addressValid  (addressValid),
        .dataValid     (dataValid),
        .sweepActive   (sweepActive),
        .sweepDone     (sweepDone),
        .staleSweep    (staleSweep),
        .status        (status)
    );

    typedef struct {
        logic         fa, rv, to, csr, rdy;
        logic [31:0]  gpio;
        int           addr;
        logic         av, dv, act, done, stale;
        int           last;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit fa, bit rv, bit to, bit csr, bit rdy, logic [31:0] gpio,
                               int addr, bit av, bit dv, bit act, bit done, bit stale, int last);
        vec_t r;
        r.fa = fa; r.rv = rv; r.to = to; r.csr = csr; r.rdy = rdy; r.gpio = gpio;
        r.addr = addr; r.av = av; r.dv = dv; r.act = act; r.done = done; r.stale = stale; r.last = last;
        return r;
    endfunction

    function automatic logic [31:0] st(int ovr, int last, bit stale, bit act);
        logic [7:0]  o;
        logic [15:0] l;
        o = STATS ? 8'(ovr) : 8'd0;
        l = STATS ? 16'(last) : 16'd0;
        return {o, l, 6'b0, stale, act};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic run_sweep(output int n_dv, output bit got);
        n_dv = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            csrStrobe = 1'b0;
            n_dv += int'(dataValid);
            got = sweepDone;
        end
    endtask

    task automatic csr_write(input logic [31:0] val);
        GPIO_OUT = val; csrStrobe = 1'b1;
        tick();
        csrStrobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n_dv;
        bit  got;
        int  n_done, n_av;

        // basic sweep, bpm=4
        tbl.push_back(v(0,0,0,1,1,4, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,1,4, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,1,4, 0,1,0,1,0,0,0));
        tbl.push_back(v(0,0,0,0,1,4, 1,1,1,1,0,0,0));
        tbl.push_back(v(0,0,0,0,1,4, 2,1,1,1,0,0,0));
        tbl.push_back(v(0,0,0,0,1,4, 3,1,1,1,0,0,0));
        tbl.push_back(v(0,0,0,0,1,4, 3,0,1,1,0,0,0));
        tbl.push_back(v(0,0,0,0,1,4, 0,0,0,0,1,0,5));
        tbl.push_back(v(0,0,0,0,1,4, 0,0,0,0,0,0,5));
        // timeout sweep then readoutValid+readTimeout sweep, bpm=2
        tbl.push_back(v(0,0,0,1,1,2, 0,0,0,0,0,0,5));
        tbl.push_back(v(1,0,0,0,1,2, 0,0,0,0,0,0,5));
        tbl.push_back(v(0,0,1,0,1,2, 0,1,0,1,0,1,5));
        tbl.push_back(v(0,0,0,0,1,2, 1,1,1,1,0,1,5));
        tbl.push_back(v(0,0,0,0,1,2, 1,0,1,1,0,1,5));
        tbl.push_back(v(0,0,0,0,1,2, 0,0,0,0,1,1,3));
        tbl.push_back(v(1,0,0,0,1,2, 0,0,0,0,0,1,3));
        tbl.push_back(v(0,1,1,0,1,2, 0,1,0,1,0,0,3));
        tbl.push_back(v(0,0,0,0,1,2, 1,1,1,1,0,0,3));
        tbl.push_back(v(0,0,0,0,1,2, 1,0,1,1,0,0,3));
        tbl.push_back(v(0,0,0,0,1,2, 0,0,0,0,1,0,3));
        // backpressure, bpm=3, dspReady 1,0,1,0,...
        tbl.push_back(v(0,0,0,1,1,3, 0,0,0,0,0,0,3));
        tbl.push_back(v(1,0,0,0,1,3, 0,0,0,0,0,0,3));
        tbl.push_back(v(0,1,0,0,1,3, 0,1,0,1,0,0,3));
        tbl.push_back(v(0,0,0,0,1,3, 1,1,1,1,0,0,3));
        tbl.push_back(v(0,0,0,0,0,3, 1,1,0,1,0,0,3));
        tbl.push_back(v(0,0,0,0,1,3, 2,1,1,1,0,0,3));
        tbl.push_back(v(0,0,0,0,0,3, 2,1,0,1,0,0,3));
        tbl.push_back(v(0,0,0,0,1,3, 2,0,1,1,0,0,3));
        tbl.push_back(v(0,0,0,0,0,3, 0,0,0,0,1,0,6));
        tbl.push_back(v(0,0,0,0,1,3, 0,0,0,0,0,0,6));

        // reset state
        tick();
        tick();
        chk("reset addr", 32'(readoutAddress), 0);
        chk("reset outputs", {addressValid, dataValid, sweepActive, sweepDone, staleSweep}, 0);
        chk("reset status", status, st(0, 0, 0, 0));
        sysResetN = 1'b1;

        foreach (tbl[i]) begin
            FAstrobe = tbl[i].fa; readoutValid = tbl[i].rv; readTimeout = tbl[i].to;
            csrStrobe = tbl[i].csr; dspReady = tbl[i].rdy; GPIO_OUT = tbl[i].gpio;
            tick();
            chk($sformatf("row%0d addr", i), 32'(readoutAddress), 32'(tbl[i].addr));
            chk($sformatf("row%0d flags av/dv/act/done/stale", i),
                {addressValid, dataValid, sweepActive, sweepDone, staleSweep},
                {tbl[i].av, tbl[i].dv, tbl[i].act, tbl[i].done, tbl[i].stale});
            chk($sformatf("row%0d status", i), status, st(0, tbl[i].last, tbl[i].stale, tbl[i].act));
        end
        FAstrobe = 0; readoutValid = 0; readTimeout = 0; csrStrobe = 0; dspReady = 1;

        // overrun at address 2 of 8
        csr_write(8);
        FAstrobe = 1; tick(); FAstrobe = 0;
        readoutValid = 1; tick(); readoutValid = 0;
        tick();
        tick();
        chk("pre-abort addr", 32'(readoutAddress), 2);
        FAstrobe = 1; tick(); FAstrobe = 0;
        chk("abort addr", 32'(readoutAddress), 0);
        chk("abort av/act/done", {addressValid, sweepActive, sweepDone}, 0);
        chk("abort status", status, st(1, 6, 0, 0));
        readoutValid = 1; tick(); readoutValid = 0;
        chk("abort then wait->sweep", {addressValid, 23'(readoutAddress)}, {1'b1, 23'd0});
        FAstrobe = 1;
        for (int i = 0; i < 299; i++) tick();
        FAstrobe = 0;
        chk("overrun saturate", status, st(255, 6, 0, 0));

        // csrStrobe mid-sweep does not change the running count
        readoutValid = 1; tick(); readoutValid = 0;
        GPIO_OUT = 2; csrStrobe = 1;
        run_sweep(n_dv, got);
        chk("csr mid-sweep done", 32'(got), 1);
        chk("csr mid-sweep dv count", n_dv, 8);
        chk("csr mid-sweep last cycles", status, st(255, 9, 0, 0));
        FAstrobe = 1; tick(); FAstrobe = 0;
        readoutValid = 1; tick(); readoutValid = 0;
        run_sweep(n_dv, got);
        chk("new count sweep dv count", n_dv, 2);

        // forceSweep: WAIT -> SWEEP without readoutValid, stale
        csr_write(32'h8000_0002);
        FAstrobe = 1; tick(); FAstrobe = 0;
        tick();
        chk("force sweep av/stale", {addressValid, staleSweep}, 2'b11);
        run_sweep(n_dv, got);
        chk("force sweep dv count", n_dv, 2);

        // reset at address 5 of 8
        csr_write(8);
        FAstrobe = 1; tick(); FAstrobe = 0;
        readoutValid = 1; tick(); readoutValid = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset addr", 32'(readoutAddress), 5);
        sysResetN = 0; tick(); sysResetN = 1;
        chk("mid-sweep reset addr", 32'(readoutAddress), 0);
        chk("mid-sweep reset outputs", {addressValid, dataValid, sweepActive, sweepDone, staleSweep}, 0);
        chk("mid-sweep reset status", status, 0);

        // bpmCount=0 after reset: FAstrobe ignored, no sweepDone
        n_done = 0; n_av = 0;
        FAstrobe = 1; tick(); FAstrobe = 0;
        n_av += int'(addressValid);
        readoutValid = 1; tick(); readoutValid = 0;
        n_av += int'(addressValid);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_done += int'(sweepDone);
            n_av += int'(addressValid);
        end
        chk("bpm0 no sweep", n_av, 0);
        chk("reset no sweepDone", n_done, 0);

        // first honoured FAstrobe after csr sets a count
        csr_write(2);
        FAstrobe = 1; tick(); FAstrobe = 0;
        readoutValid = 1; tick(); readoutValid = 0;
        chk("post-config sweep start", {addressValid, 23'(readoutAddress)}, {1'b1, 23'd0});
        run_sweep(n_dv, got);
        chk("post-config sweep done", 32'(got), 1);
        chk("post-config dv count", n_dv, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
